// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mdu_pkg
// Purpose : Shared types and constants for the iterative multiply/divide
//           sequencer (mdu_seq) and the execute-stage ALU decoder.
//           - op_e    : 3-bit MDU operation encoding
//           - state_e : sequencer FSM states (FIXIN/FIXOUT only reachable
//                       when MDU_SIGNED_EN is defined)
//           - ALU_ADD / ALU_SUB : shared ALU op codes
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package mdu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [2:0] {
    OP_MUL   = 3'b000,
    OP_MULH  = 3'b001,
    OP_MULHU = 3'b010,
    OP_DIV   = 3'b100,
    OP_DIVU  = 3'b101,
    OP_REM   = 3'b110,
    OP_REMU  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_DONE   = 3'd2,
    ST_FIXIN  = 3'd3,
    ST_FIXOUT = 3'd4
  } state_e;

  // Bit 2 of the op code separates the divide family from the multiply family.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module  : mdu_seq
// Purpose : Iterative MUL/MULH/MULHU/DIV/DIVU/REM/REMU sequencer that borrows
//           the shared 32-bit integer ALU, one ALU operation per cycle.
//           Shift-add multiply and restoring divide, ITER iterations each.
//           Optional macro MDU_SIGNED_EN adds FIXIN/FIXOUT states that take
//           absolute values of operands and re-apply the result sign; without
//           it MULH/DIV/REM execute as MULHU/DIVU/REMU.
// Ports   : clk_i, rst_ni (async active-low)
//           req_valid_i/req_ready_o, op_i, rs1_i, rs2_i : request
//           flush_i                                     : synchronous abort
//           alu_op_o, alu_a_o, alu_b_o, alu_data_i      : shared ALU access
//           alu_busy_o                                  : ALU ownership
//           resp_valid_o/resp_ready_i, result_o         : response
// Rev     : 1.0  initial release
// ============================================================================
module mdu_seq #(
  parameter int XLEN = mdu_pkg::XLEN,
  parameter int ITER = XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  input  logic [XLEN-1:0] alu_data_i,
  output logic            alu_busy_o,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o
);
  import mdu_pkg::*;

  localparam int CW = $clog2(ITER);

  state_e          state, state_nx;
  logic [2:0]      op_q;
  logic [XLEN-1:0] hi, lo;       // mul: {hi,lo} product/multiplier; div: hi=rem, lo=dividend->quotient
  logic [XLEN-1:0] opb;          // multiplicand or divisor
  logic [CW-1:0]   cnt;

  logic            accept, div0, last, take, carry;
  logic [XLEN-1:0] shifted, calc_hi, calc_lo, fin_res;

`ifdef MDU_SIGNED_EN
  logic            neg_a_pend, neg_b_pend, neg_res, sgn_req;
  logic [XLEN-1:0] fix_res;
  assign sgn_req = op_is_signed(op_i);
`endif

  assign req_ready_o  = (state == ST_IDLE);
  assign resp_valid_o = (state == ST_DONE);
  assign alu_busy_o   = (state != ST_IDLE) && (state != ST_DONE);

  assign accept = req_valid_i && (state == ST_IDLE) && !flush_i;
  assign div0   = op_is_div(op_i) && (rs2_i == '0);
  assign last   = (cnt == CW'(ITER - 1));

  always_comb begin
    state_nx = state;
    alu_op_o = ALU_ADD;
    alu_a_o  = '0;
    alu_b_o  = '0;
    calc_hi  = hi;
    calc_lo  = lo;
    shifted  = '0;
    take     = 1'b0;
    carry    = 1'b0;
`ifdef MDU_SIGNED_EN
    fix_res  = '0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (div0) begin
            state_nx = ST_DONE;
`ifdef MDU_SIGNED_EN
          end else if (sgn_req && (rs1_i[XLEN-1] || rs2_i[XLEN-1])) begin
            state_nx = ST_FIXIN;
`endif
          end else begin
            state_nx = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (op_is_div(op_q)) begin
          // Restoring step: the bit shifted out of rem forces acceptance,
          // since the 33-bit partial remainder then exceeds any divisor.
          shifted  = {hi[XLEN-2:0], lo[XLEN-1]};
          alu_op_o = ALU_SUB;
          alu_a_o  = shifted;
          alu_b_o  = opb;
          take     = hi[XLEN-1] || (shifted >= opb);
          calc_hi  = take ? alu_data_i : shifted;
          calc_lo  = {lo[XLEN-2:0], take};
        end else begin
          alu_op_o = ALU_ADD;
          alu_a_o  = hi;
          alu_b_o  = opb;
          if (lo[0]) begin
            carry   = (alu_data_i < hi);
            calc_hi = {carry, alu_data_i[XLEN-1:1]};
            calc_lo = {alu_data_i[0], lo[XLEN-1:1]};
          end else begin
            calc_hi = {1'b0, hi[XLEN-1:1]};
            calc_lo = {hi[0], lo[XLEN-1:1]};
          end
        end
        if (last) begin
`ifdef MDU_SIGNED_EN
          state_nx = neg_res ? ST_FIXOUT : ST_DONE;
`else
          state_nx = ST_DONE;
`endif
        end
      end
      ST_DONE: begin
        if (resp_ready_i) state_nx = ST_IDLE;
      end
`ifdef MDU_SIGNED_EN
      ST_FIXIN: begin
        // Dividend/multiplicand first, then divisor/multiplier.
        alu_op_o = ALU_SUB;
        if (neg_a_pend) alu_b_o = op_is_div(op_q) ? lo : opb;
        else            alu_b_o = op_is_div(op_q) ? opb : lo;
        state_nx = (neg_a_pend && neg_b_pend) ? ST_FIXIN : ST_CALC;
      end
      ST_FIXOUT: begin
        alu_op_o = ALU_SUB;
        alu_b_o  = fin_res;
        // Upper half of a negated 64-bit product: -{hi,lo} borrows into hi
        // unless lo is zero, leaving ~hi.
        if (!op_is_div(op_q) && (lo != '0)) fix_res = ~hi;
        else                                fix_res = alu_data_i;
        state_nx = ST_DONE;
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
    if (flush_i) state_nx = ST_IDLE;
  end

  // Result selection from the (next) hi/lo values: lo for MUL/quotient,
  // hi for high product/remainder.
  always_comb begin
    if (op_is_div(op_q)) fin_res = op_q[1] ? calc_hi : calc_lo;
    else                 fin_res = (op_q[1:0] == 2'b00) ? calc_lo : calc_hi;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      hi       <= '0;
      lo       <= '0;
      opb      <= '0;
      cnt      <= '0;
      result_o <= '0;
`ifdef MDU_SIGNED_EN
      neg_a_pend <= 1'b0;
      neg_b_pend <= 1'b0;
      neg_res    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= op_i;
            cnt  <= '0;
            hi   <= '0;
            if (op_is_div(op_i)) begin
              lo  <= rs1_i;
              opb <= rs2_i;
            end else begin
              lo  <= rs2_i;
              opb <= rs1_i;
            end
            if (div0) result_o <= op_i[1] ? rs1_i : '1;
`ifdef MDU_SIGNED_EN
            neg_a_pend <= sgn_req && rs1_i[XLEN-1];
            neg_b_pend <= sgn_req && rs2_i[XLEN-1];
            // REM takes the dividend sign; MULH/DIV take the product sign.
            neg_res    <= sgn_req && ((op_i == OP_REM) ? rs1_i[XLEN-1]
                                                       : (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]));
`endif
          end
        end
        ST_CALC: begin
          hi  <= calc_hi;
          lo  <= calc_lo;
          cnt <= cnt + CW'(1);
          if (last) result_o <= fin_res;
        end
`ifdef MDU_SIGNED_EN
        ST_FIXIN: begin
          if (neg_a_pend) begin
            if (op_is_div(op_q)) lo  <= alu_data_i;
            else                 opb <= alu_data_i;
            neg_a_pend <= 1'b0;
          end else begin
            if (op_is_div(op_q)) opb <= alu_data_i;
            else                 lo  <= alu_data_i;
            neg_b_pend <= 1'b0;
          end
        end
        ST_FIXOUT: begin
          result_o <= fix_res;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
